// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV64 pipeline: PC and inter-stage hold/clear strobes.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic              ex_busy,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic [1:0]        id_rs_used,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic              ex_is_load,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              trap_valid,
    input  logic [ADDR_W-1:0] trap_target,
    output logic              pc_hold,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              hold_ifid,
    output logic              hold_idex,
    output logic              hold_exmem,
    output logic              hold_memwb,
    output logic              clear_ifid,
    output logic              clear_idex,
    output logic              clear_exmem,
`ifdef PIPE_CTRL_PERF_EN
    output logic [63:0]       perf_stall_cnt,
    output logic [63:0]       perf_flush_cnt,
    output logic [63:0]       perf_lu_cnt,
`endif
    output logic              clear_memwb
);

    typedef enum logic [0:0] {StRun, StRedirPend} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;

    logic trap_eff;
    logic load_use;
    logic down_stall;

    // A trap seen while the MEM access is still outstanding waits for it to finish.
    assign trap_eff   = trap_valid & ~mem_busy;
    assign down_stall = mem_busy | ex_busy;
    assign load_use   = ex_is_load && (ex_rd != '0) &&
                        ((id_rs_used[0] && (id_rs1 == ex_rd)) ||
                         (id_rs_used[1] && (id_rs2 == ex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        case (state_q)
            StRun: begin
                if (!trap_eff && !down_stall && br_valid && if_busy) begin
                    state_d       = StRedirPend;
                    pend_target_d = br_target;
                end
            end
            StRedirPend: begin
                if (trap_eff || !if_busy) begin
                    state_d       = StRun;
                    pend_target_d = '0;
                end
            end
            default: begin
                state_d       = StRun;
                pend_target_d = '0;
            end
        endcase
    end

    always_comb begin
        pc_hold     = 1'b0;
        pc_load     = 1'b0;
        pc_target   = '0;
        hold_ifid   = 1'b0;
        hold_idex   = 1'b0;
        hold_exmem  = 1'b0;
        hold_memwb  = 1'b0;
        clear_ifid  = 1'b0;
        clear_idex  = 1'b0;
        clear_exmem = 1'b0;
        clear_memwb = 1'b0;
        if (rst) begin
            clear_ifid  = 1'b1;
            clear_idex  = 1'b1;
            clear_exmem = 1'b1;
            clear_memwb = 1'b1;
        end else if (trap_eff) begin
            clear_ifid  = 1'b1;
            clear_idex  = 1'b1;
            clear_exmem = 1'b1;
            clear_memwb = 1'b1;
            pc_load     = 1'b1;
            pc_target   = trap_target;
        end else begin
            if (mem_busy) begin
                hold_idex   = 1'b1;
                hold_exmem  = 1'b1;
                clear_memwb = 1'b1;
            end else if (ex_busy) begin
                hold_idex   = 1'b1;
                clear_exmem = 1'b1;
            end
            // While a redirect is deferred, the PC and IF/ID follow the pending redirect only.
            if (state_q == StRedirPend) begin
                clear_ifid = 1'b1;
                if (if_busy) begin
                    pc_hold = 1'b1;
                end else begin
                    pc_load   = 1'b1;
                    pc_target = pend_target_q;
                end
            end else if (down_stall) begin
                pc_hold   = 1'b1;
                hold_ifid = 1'b1;
            end else if (br_valid) begin
                clear_ifid = 1'b1;
                clear_idex = 1'b1;
                if (if_busy) begin
                    pc_hold = 1'b1;
                end else begin
                    pc_load   = 1'b1;
                    pc_target = br_target;
                end
            end else if (load_use) begin
                pc_hold    = 1'b1;
                hold_ifid  = 1'b1;
                clear_idex = 1'b1;
            end else if (if_busy) begin
                pc_hold    = 1'b1;
                clear_ifid = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic lu_bubble;

    assign lu_bubble = (state_q == StRun) && !trap_eff && !down_stall && !br_valid && load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_lu_cnt    <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + 64'(pc_hold);
            perf_flush_cnt <= perf_flush_cnt + 64'(pc_load);
            perf_lu_cnt    <= perf_lu_cnt + 64'(lu_bubble);
        end
    end
`endif

endmodule
